// File: rtl/nrzi_pkg.sv
// Shared definitions for the toggle-encoded (NRZI-style) serial link.
// The transmitter side uses the same frame constants, so keep them here.
package nrzi_pkg;

   // Receiver framing states: hunting for the sync byte, or inside a frame.
   typedef enum logic {
      HUNT = 1'b0,
      RECV = 1'b1
   } rx_state_e;

   // Frame-start pattern, compared against decoded bits. Never delivered.
   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   // Consecutive decoded zeros that terminate a frame (legal 9..255).
   localparam int unsigned IDLE_BITS_DEFAULT = 16;

   // Bytes travel LSB first: a new bit enters at the top and the
   // register moves right, so after eight bits the first one sits at bit 0.
   function automatic logic [7:0] shift_in_lsb_first(input logic [7:0] sr,
                                                     input logic       b);
      return {b, sr[7:1]};
   endfunction

endpackage

// File: rtl/nrzi_byte_receiver_if.sv
// Byte stream leaving the receiver: one-entry valid/ready handshake.
// The receiver is the master (drives data/valid), the consumer the slave.
interface nrzi_byte_receiver_if;

   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;

   modport master (
      output out_data,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      output out_ready
   );

endinterface

// File: rtl/nrzi_bit_decoder.sv
// Toggle-line bit recovery: a line change since the previous sampled bit
// means 1, a held level means 0. Only bit_en cycles are considered samples.
module nrzi_bit_decoder (
   input  logic clk,
   input  logic rst_n,
   input  logic bit_en,
   input  logic line_in,
   output logic rx_bit,
   output logic bit_valid
);

   logic prev_line;

   // Remember the line level at each bit sample; the first bit after reset
   // is decoded against a low line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_line <= 1'b0;
      end else if (bit_en) begin
         // NOTE: registers are written with <= so every flop samples the
         // pre-edge values; a blocking = here would let later reads in the
         // same block see the new value and break the edge semantics.
         prev_line <= line_in;
      end
   end

   // Decoded bit is valid in exactly the cycles that carry a line sample.
   assign rx_bit    = line_in ^ prev_line;
   assign bit_valid = bit_en;

endmodule

// File: rtl/nrzi_byte_receiver.sv
// Receive side of the toggle-encoded serial link: decodes line bits, hunts
// for the sync byte, assembles LSB-first bytes inside a frame and offers them
// through a one-entry valid/ready holding register. A long run of decoded
// zeros closes the frame and returns to hunting.
module nrzi_byte_receiver
   import nrzi_pkg::*;
#(
   parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT,
   parameter int unsigned IDLE_BITS = IDLE_BITS_DEFAULT   // legal 9..255
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        bit_en,
   input  logic                        line_in,
   nrzi_byte_receiver_if.master        out_if,
   output logic                        in_frame,
   output logic                        frame_end,
   output logic                        overrun
);

   // The zero-run counter is 8 bits wide, which is why IDLE_BITS stops at 255.
   localparam logic [7:0] IDLE_LIMIT = IDLE_BITS[7:0];

   // ------------------------------------------------------------------
   // Bit recovery
   // ------------------------------------------------------------------
   logic rx_bit;
   logic bit_valid;

   nrzi_bit_decoder u_decoder (
      .clk       (clk),
      .rst_n     (rst_n),
      .bit_en    (bit_en),
      .line_in   (line_in),
      .rx_bit    (rx_bit),
      .bit_valid (bit_valid)
   );

   // ------------------------------------------------------------------
   // Framing state and assembly registers
   // ------------------------------------------------------------------
   rx_state_e  state;
   rx_state_e  state_next;
   logic [7:0] shift_reg;
   logic [7:0] shift_next;
   logic [2:0] bit_cnt;
   logic [2:0] bit_cnt_next;
   logic [7:0] zero_cnt;
   logic [7:0] zero_cnt_next;

   // Per-bit decisions produced by the next-state logic.
   logic [7:0] shifted;
   logic [7:0] zero_run;
   logic       byte_done;
   logic       frame_done;

   // State and assembly registers; idle cycles (bit_en low) leave them alone
   // because the next-state logic then returns the current values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= HUNT;
         shift_reg <= 8'h00;
         bit_cnt   <= 3'd0;
         zero_cnt  <= 8'h00;
         frame_end <= 1'b0;
      end else begin
         state     <= state_next;
         shift_reg <= shift_next;
         bit_cnt   <= bit_cnt_next;
         zero_cnt  <= zero_cnt_next;
         frame_end <= frame_done;
      end
   end

   // Next-state logic: sync hunt, byte assembly and end-of-frame detection.
   always_comb begin
      // NOTE: every signal driven here gets a default before any branch, so
      // no path leaves one unassigned and no latch is inferred.
      state_next    = state;
      shift_next    = shift_reg;
      bit_cnt_next  = bit_cnt;
      zero_cnt_next = zero_cnt;
      shifted       = shift_in_lsb_first(shift_reg, rx_bit);
      zero_run      = zero_cnt;
      byte_done     = 1'b0;
      frame_done    = 1'b0;

      if (bit_valid) begin
         unique case (state)
            HUNT: begin
               shift_next = shifted;
               if (shifted == SYNC_BYTE) begin
                  state_next    = RECV;
                  bit_cnt_next  = 3'd0;
                  zero_cnt_next = 8'h00;
               end
            end

            RECV: begin
               // A 1 breaks the idle run; a 0 extends it up to the limit.
               if (rx_bit) begin
                  zero_run = 8'h00;
               end else if (zero_cnt >= IDLE_LIMIT) begin
                  zero_run = IDLE_LIMIT;
               end else begin
                  zero_run = zero_cnt + 8'd1;
               end
               zero_cnt_next = zero_run;

               if (zero_run == IDLE_LIMIT) begin
                  // Frame over: a byte this bit would have completed is
                  // idle filler, so it is thrown away with the partial data.
                  state_next   = HUNT;
                  frame_done   = 1'b1;
                  shift_next   = 8'h00;
                  bit_cnt_next = 3'd0;
               end else begin
                  shift_next   = shifted;
                  bit_cnt_next = bit_cnt + 3'd1;   // wraps 7 -> 0 per byte
                  byte_done    = (bit_cnt == 3'd7);
               end
            end

            default: begin
               state_next = HUNT;
            end
         endcase
      end
   end

   // in_frame is a decode of the state flop, so it changes on the same edge.
   assign in_frame = (state == RECV);

   // ------------------------------------------------------------------
   // One-entry holding register towards the consumer
   // ------------------------------------------------------------------

   // Load a completed byte when the slot is free or being emptied this
   // cycle; otherwise drop it and flag the loss for one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_if.out_data  <= 8'h00;
         out_if.out_valid <= 1'b0;
         overrun          <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (byte_done) begin
            if (!out_if.out_valid || out_if.out_ready) begin
               out_if.out_data  <= shifted;
               out_if.out_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (out_if.out_valid && out_if.out_ready) begin
            out_if.out_valid <= 1'b0;
         end
      end
   end

endmodule
